cpu_aux_units: RTL and testbench

- Auxiliary datapath unit for the 16-bit-instruction / 10-bit-PC CPU.
- Bundles three sub-functions:
  - Combinational 8-bit ALU with zero flag; feeds the Z flip-flop and the register-file write mux.
  - Combinational 4-to-2 priority encoder for the four interrupt-enable lines; selects the interrupt vector register and drives the PC-override mux.
  - Synchronous clock divider producing a slow clock and a one-cycle tick.
- Only the divider holds state.

---
 rtl/cpu_aux_units.sv | 92 +++++++++
 tb/tb_cpu_aux_units.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cpu_aux_units.sv
// Auxiliary datapath for the 16-bit CPU: combinational ALU, interrupt priority
// encoder and an enable-gated clock divider with a registered rise tick.
module cpu_aux_units #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [2:0]       op_alu,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_z,
  input  logic             ie1,
  input  logic             ie2,
  input  logic             ie3,
  input  logic             ie4,
  output logic [1:0]       int_sel,
  output logic             int_any,
  input  logic             div_en,
  output logic             clk_out,
  output logic             div_tick
);

  localparam int HALF = DIVISOR / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;
  logic          wrap;

  always_comb begin
    alu_y = alu_a;
    case (op_alu)
      3'b000:  alu_y = alu_a;
      3'b001:  alu_y = ~alu_a;
      3'b010:  alu_y = alu_a + alu_b;
      3'b011:  alu_y = alu_a - alu_b;
      3'b100:  alu_y = alu_a & alu_b;
      3'b101:  alu_y = alu_a | alu_b;
      3'b110:  alu_y = -alu_a;
      default: alu_y = -alu_b;
    endcase
  end

  assign alu_z = (alu_y == '0);

  // ie1 has the highest priority; with no request int_sel falls back to 00.
  always_comb begin
    int_sel = 2'b00;
    if (ie1)      int_sel = 2'b00;
    else if (ie2) int_sel = 2'b01;
    else if (ie3) int_sel = 2'b10;
    else if (ie4) int_sel = 2'b11;
  end

  assign int_any = ie1 | ie2 | ie3 | ie4;

  always_comb begin
    wrap      = div_en && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    if (div_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Tick is registered alongside the 0->1 toggle so both change on the same edge.
    tick_d = wrap && !clk_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign div_tick = tick_q;

endmodule

// File: tb/tb_cpu_aux_units.sv
// Self-checking bench for cpu_aux_units: vector tables, random ALU/divider
// stimulus against an arithmetic reference model, and reset/hold sequences.
module tb_cpu_aux_units;

  localparam int WIDTH   = 8;
  localparam int DIVISOR = 4;
  localparam int HALF    = DIVISOR / 2;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       op_alu;
  logic [WIDTH-1:0] alu_y;
  logic             alu_z;
  logic             ie1, ie2, ie3, ie4;
  logic [1:0]       int_sel;
  logic             int_any;
  logic             div_en;
  logic             clk_out;
  logic             div_tick;

  int checks = 0;
  int errors = 0;
  int enEdges = 0;

  cpu_aux_units #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
    .clk(clk), .reset(reset),
    .alu_a(alu_a), .alu_b(alu_b), .op_alu(op_alu), .alu_y(alu_y), .alu_z(alu_z),
    .ie1(ie1), .ie2(ie2), .ie3(ie3), .ie4(ie4), .int_sel(int_sel), .int_any(int_any),
    .div_en(div_en), .clk_out(clk_out), .div_tick(div_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       z;
  } aluVec_t;

  typedef struct {
    logic [3:0] ie;
    logic [1:0] sel;
    logic       any;
  } encVec_t;

  aluVec_t aluTab[11];
  encVec_t encTab[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] aluModel(input int a, input int b, input int op);
    int r;
    case (op)
      0: r = a;
      1: r = 255 - a;
      2: r = (a + b) % 256;
      3: r = (a - b + 256) % 256;
      4: r = a & b;
      5: r = a | b;
      6: r = (256 - a) % 256;
      default: r = (256 - b) % 256;
    endcase
    return 8'(r);
  endfunction

  // One clk edge with the given enable; the model counts enabled edges since reset.
  task automatic applyStimulus(input logic en, input string name);
    logic expClk, expTick;
    div_en = en;
    @(posedge clk);
    #1;
    if (en) enEdges++;
    expClk  = ((enEdges / HALF) % 2) == 1;
    expTick = en && ((enEdges % DIVISOR) == HALF);
    checkOutput({name, ".clk_out"}, {31'b0, clk_out}, {31'b0, expClk});
    checkOutput({name, ".tick"}, {31'b0, div_tick}, {31'b0, expTick});
  endtask

  initial begin
    aluTab[0]  = '{8'h35, 8'h0A, 3'b000, 8'h35, 1'b0};
    aluTab[1]  = '{8'h35, 8'h0A, 3'b001, 8'hCA, 1'b0};
    aluTab[2]  = '{8'h35, 8'h0A, 3'b010, 8'h3F, 1'b0};
    aluTab[3]  = '{8'h35, 8'h0A, 3'b011, 8'h2B, 1'b0};
    aluTab[4]  = '{8'h35, 8'h0A, 3'b100, 8'h00, 1'b1};
    aluTab[5]  = '{8'h35, 8'h0A, 3'b101, 8'h3F, 1'b0};
    aluTab[6]  = '{8'h35, 8'h0A, 3'b110, 8'hCB, 1'b0};
    aluTab[7]  = '{8'h35, 8'h0A, 3'b111, 8'hF6, 1'b0};
    aluTab[8]  = '{8'hFF, 8'h01, 3'b010, 8'h00, 1'b1};
    aluTab[9]  = '{8'hFF, 8'h01, 3'b011, 8'hFE, 1'b0};
    aluTab[10] = '{8'h00, 8'h01, 3'b110, 8'h00, 1'b1};

    encTab[0]  = '{4'b0000, 2'd0, 1'b0};
    encTab[1]  = '{4'b0001, 2'd3, 1'b1};
    encTab[2]  = '{4'b0010, 2'd2, 1'b1};
    encTab[3]  = '{4'b0011, 2'd2, 1'b1};
    encTab[4]  = '{4'b0100, 2'd1, 1'b1};
    encTab[5]  = '{4'b0101, 2'd1, 1'b1};
    encTab[6]  = '{4'b0110, 2'd1, 1'b1};
    encTab[7]  = '{4'b0111, 2'd1, 1'b1};
    for (int i = 8; i < 16; i++) encTab[i] = '{4'(i), 2'd0, 1'b1};

    reset = 1'b0; div_en = 1'b0;
    alu_a = '0; alu_b = '0; op_alu = '0;
    {ie1, ie2, ie3, ie4} = 4'b0000;
    #2;
    checkOutput("rst.clk_out", {31'b0, clk_out}, 32'd0);
    checkOutput("rst.tick", {31'b0, div_tick}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      alu_a = aluTab[i].a; alu_b = aluTab[i].b; op_alu = aluTab[i].op;
      #1;
      checkOutput($sformatf("aluTab%0d.y", i), {24'b0, alu_y}, {24'b0, aluTab[i].y});
      checkOutput($sformatf("aluTab%0d.z", i), {31'b0, alu_z}, {31'b0, aluTab[i].z});
    end

    for (int i = 0; i < 16; i++) begin
      {ie1, ie2, ie3, ie4} = encTab[i].ie;
      #1;
      checkOutput($sformatf("enc%0d.sel", i), {30'b0, int_sel}, {30'b0, encTab[i].sel});
      checkOutput($sformatf("enc%0d.any", i), {31'b0, int_any}, {31'b0, encTab[i].any});
    end

    for (int i = 0; i < 200; i++) begin
      logic [7:0] ey;
      alu_a = 8'($urandom); alu_b = 8'($urandom); op_alu = 3'($urandom);
      #1;
      ey = aluModel(int'(alu_a), int'(alu_b), int'(op_alu));
      checkOutput("aluRnd.y", {24'b0, alu_y}, {24'b0, ey});
      checkOutput("aluRnd.z", {31'b0, alu_z}, {31'b0, ey == 8'h00});
    end

    // Release reset between edges, then run the basic enabled sequence.
    @(posedge clk); #1;
    reset = 1'b1; enEdges = 0;
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, "divRun");

    // Freeze while clk_out is high (enEdges%4 == 2 or 3), then resume.
    while ((enEdges % DIVISOR) != 3) applyStimulus(1'b1, "divAlign");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, "divHold");
      checkOutput("divHold.high", {31'b0, clk_out}, 32'd1);
    end
    applyStimulus(1'b1, "divResume");
    checkOutput("divResume.fall", {31'b0, clk_out}, 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, "divResume");

    // Async reset between edges while clk_out is high.
    while ((enEdges % DIVISOR) != HALF) applyStimulus(1'b1, "divAlign2");
    checkOutput("preRst.clk_out", {31'b0, clk_out}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("asyncRst.clk_out", {31'b0, clk_out}, 32'd0);
    checkOutput("asyncRst.tick", {31'b0, div_tick}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; enEdges = 0;
    applyStimulus(1'b1, "postRst");
    checkOutput("postRst.edge1", {31'b0, clk_out}, 32'd0);
    applyStimulus(1'b1, "postRst");
    checkOutput("postRst.edge2", {31'b0, clk_out}, 32'd1);
    checkOutput("postRst.tick2", {31'b0, div_tick}, 32'd1);

    for (int i = 0; i < 300; i++) applyStimulus(1'($urandom_range(0, 1)), "divRnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
